layer_input_serializer: RTL and testbench
=========================================

// Module: layer_input_serializer
// PURPOSE
//   Upstream feeder for the serial neuron layer: accepts a full input vector in parallel
//   (valid/ready) and streams it one element per cycle on the layer's serial x input,
//   marking first/last elements. Ping-pong double buffer lets the next vector be loaded
//   while the current one streams, so back-to-back frames run with no bubble.
// PARAMETERS
//   VEC_SIZE  3  elements per input vector (>=1); equals upstream layer size
//   BIT_SIZE  1  width of one element
// PORTS
//   clk       in   1                  clock, all state on rising edge
//   rst       in   1                  synchronous, active-high reset
//   in_valid  in   1                  in_vec holds a vector to load
//   in_ready  out  1                  buffer slot free; load occurs when in_valid&&in_ready
//   in_vec    in   VEC_SIZE*BIT_SIZE  element k at bits [k*BIT_SIZE +: BIT_SIZE]
//   x         out  BIT_SIZE           current serial element
//   x_valid   out  1                  x holds a valid element
//   x_ready   in   1                  consumer takes x this cycle when x_valid&&x_ready
//   x_first   out  1                  x is element 0 of its vector (qualified by x_valid)
//   x_last    out  1                  x is element VEC_SIZE-1 (qualified by x_valid)
//   idx       out  $clog2(VEC_SIZE)   index of element on x (width min 1)
//   busy      out  1                  at least one vector buffered or streaming
// BEHAVIOUR
// - State: buf[0..1] (VEC_SIZE*BIT_SIZE each), wr_ptr, rd_ptr (1 bit), count (0..2),
//   idx counter. Occupancy FSM: EMPTY(count=0) / ONE(1) / FULL(2).
// - Reset (rst=1 at edge): count=0, wr_ptr=rd_ptr=0, idx=0; buffer contents don't care.
//   While rst is high and after: x_valid=0, busy=0, x_first=x_last=0; in_ready=0 while rst
//   is high, 1 from first cycle after release. x = 0 whenever x_valid=0.
// - in_ready = (count<2) && !rst. On load: buf[wr_ptr]<=in_vec, wr_ptr toggles.
// - x_valid = (count>0). x = buf[rd_ptr][idx]. x_first=(idx==0), x_last=(idx==VEC_SIZE-1).
// - Latency: vector loaded at edge t into EMPTY -> x_valid=1, idx=0 in cycle after t.
// - Advance on x_valid&&x_ready: if idx<VEC_SIZE-1, idx++; else idx<=0, rd_ptr toggles,
//   vector retired. x_ready=0: x, idx, flags held stable (no drop, no repeat).
// - count next: +1 on load only, -1 on retire only, unchanged on simultaneous load+retire
//   (incl. FULL: retire frees slot but in_ready is already 0 that cycle -> no load).
// - Back-to-back: with x_ready=1 and next vector loaded before retire, element 0 of next
//   vector follows element VEC_SIZE-1 on the very next cycle (no bubble).
// - Buffer being streamed is never overwritten: wr_ptr==rd_ptr only when count==0
//   or count==2 (in_ready=0).
// - VEC_SIZE=1: x_first=x_last=1 on every valid element; every accepted transfer retires.
// - rst mid-stream: discards both buffers, same state as power-on reset, no partial
//   vector emitted afterwards.
// - busy = (count>0).
// TESTING
// 1 Reset: rst high 2 cycles, in_valid=1 -> in_ready=0, x_valid=0; after release
//   in_ready=1, busy=0, nothing loaded during reset.
// 2 Single frame VEC_SIZE=3, BIT_SIZE=8, in_vec={8'h33,8'h22,8'h11}, x_ready=1 -> x =
//   11,22,33 on 3 consecutive cycles starting 1 cycle after load; first on 11, last on 33.
// 3 Back-to-back: load A then B immediately, x_ready=1 -> 6 contiguous valid cycles
//   A0..A2,B0..B2; third vector C sees in_ready=0 until A retires, then loads.
// 4 Backpressure: x_ready=0 for 4 cycles mid-vector at idx=1 -> x, idx, flags stable;
//   resume -> idx=2 next, no element lost or duplicated.
// 5 Simultaneous load+retire in ONE state -> count stays 1, next vector starts next
//   cycle with x_first=1; rst asserted at idx=1 -> x_valid=0 next cycle, busy=0.
// 6 VEC_SIZE=1 -> each vector emits one element with x_first=x_last=1; throughput
//   1 vector/cycle with in_valid and x_ready held high.

Source files
------------

// File: rtl/layer_input_serializer.sv
// Ping-pong double-buffered vector loader that streams one element per cycle to the
// serial neuron layer, with first/last markers and zero-bubble back-to-back frames.
module layer_input_serializer #(
  parameter  int VEC_SIZE = 3,
  parameter  int BIT_SIZE = 1,
  localparam int IW       = (VEC_SIZE > 1) ? $clog2(VEC_SIZE) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [VEC_SIZE*BIT_SIZE-1:0] in_vec,
  output logic [BIT_SIZE-1:0]          x,
  output logic                         x_valid,
  input  logic                         x_ready,
  output logic                         x_first,
  output logic                         x_last,
  output logic [IW-1:0]                idx,
  output logic                         busy
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

  state_e                              state_q, state_d;
  logic [1:0][VEC_SIZE*BIT_SIZE-1:0]   vbuf_q, vbuf_d;
  logic                                wr_ptr_q, wr_ptr_d;
  logic                                rd_ptr_q, rd_ptr_d;
  logic [IW-1:0]                       idx_q, idx_d;
  logic                                load, adv, retire, last_idx;
  logic [BIT_SIZE-1:0]                 elem;

  assign last_idx = (idx_q == IW'(VEC_SIZE - 1));
  assign elem     = vbuf_q[rd_ptr_q][int'(idx_q)*BIT_SIZE +: BIT_SIZE];

  // Outputs are forced quiet while rst is high so nothing leaks before the reset edge.
  assign in_ready = (state_q != FULL) && !rst;
  assign x_valid  = (state_q != EMPTY) && !rst;
  assign busy     = x_valid;
  assign x        = x_valid ? elem : '0;
  assign x_first  = x_valid && (idx_q == '0);
  assign x_last   = x_valid && last_idx;
  assign idx      = idx_q;

  always_comb begin
    load     = in_valid && in_ready;
    adv      = x_valid && x_ready;
    retire   = adv && last_idx;
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q ^ load;
    rd_ptr_d = rd_ptr_q ^ retire;
    idx_d    = idx_q;
    vbuf_d   = vbuf_q;
    if (adv) idx_d = retire ? '0 : idx_q + IW'(1);
    if (load) vbuf_d[wr_ptr_q] = in_vec;
    // Simultaneous load and retire leaves occupancy unchanged.
    case (state_q)
      EMPTY:   if (load) state_d = ONE;
      ONE: begin
        if (load && !retire)      state_d = FULL;
        else if (retire && !load) state_d = EMPTY;
      end
      FULL:    if (retire) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= EMPTY;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      idx_q    <= idx_d;
    end
  end

  // Buffer contents are don't-care after reset; occupancy alone says what is live.
  always_ff @(posedge clk) begin
    vbuf_q <= vbuf_d;
  end

endmodule

// File: tb/tb_layer_input_serializer.sv
// Bench for layer_input_serializer: a VEC_SIZE=3 and a VEC_SIZE=1 instance share stimulus
// and are each compared every cycle against a queue-based frame model.
module tb_layer_input_serializer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, x_ready;
  logic [23:0] in_vec;
  logic        ir3, xv3, xf3, xl3, bz3, ir1, xv1, xf1, xl1, bz1;
  logic [7:0]  x3, x1;
  logic [1:0]  idx3;
  logic [0:0]  idx1;

  layer_input_serializer #(.VEC_SIZE(3), .BIT_SIZE(8)) d3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir3), .in_vec(in_vec),
    .x(x3), .x_valid(xv3), .x_ready(x_ready), .x_first(xf3), .x_last(xl3),
    .idx(idx3), .busy(bz3));

  layer_input_serializer #(.VEC_SIZE(1), .BIT_SIZE(8)) d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .in_vec(in_vec[7:0]),
    .x(x1), .x_valid(xv1), .x_ready(x_ready), .x_first(xf1), .x_last(xl1),
    .idx(idx1), .busy(bz1));

  int n_chk = 0, n_pass = 0, vcnt = 0, cw;
  logic [23:0] q3[$], q1[$];
  int pos3 = 0, pos1 = 0;

  typedef struct {
    logic rst, iv, xr; logic [23:0] vec;
    logic e_ir, e_xv; logic [7:0] e_x; logic e_f, e_l; logic [1:0] e_idx;
  } vec_t;
  vec_t tv[7];

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endfunction

  // Frame model: queue holds whole vectors, pos is the element being offered.
  function automatic void model_chk(string nm, input logic [23:0] q[$], int pos, int vs,
      logic ir, logic xv, logic xf, logic xl, logic bz, logic [7:0] x, logic [1:0] ix);
    logic ev = (q.size() > 0) && !rst;
    logic [23:0] h = '0;
    logic [7:0] ex;
    if (ev) h = q[0];
    ex = ev ? h[pos*8 +: 8] : 8'h00;
    chk({nm, ".in_ready"}, 32'(ir), 32'((q.size() < 2) && !rst));
    chk({nm, ".x_valid"},  32'(xv), 32'(ev));
    chk({nm, ".busy"},     32'(bz), 32'(ev));
    chk({nm, ".x"},        32'(x),  32'(ex));
    chk({nm, ".x_first"},  32'(xf), 32'(ev && pos == 0));
    chk({nm, ".x_last"},   32'(xl), 32'(ev && pos == vs - 1));
    if (ev) chk({nm, ".idx"}, 32'(ix), 32'(pos));
  endfunction

  function automatic void model_upd(inout logic [23:0] q[$], inout int pos, input int vs);
    logic ld   = in_valid && (q.size() < 2);
    logic fire = (q.size() > 0) && x_ready;
    if (rst) begin
      q.delete(); pos = 0;
    end else begin
      if (fire) begin
        pos++;
        if (pos == vs) begin pos = 0; void'(q.pop_front()); end
      end
      if (ld) q.push_back(in_vec);
    end
  endfunction

  task automatic tick();
    @(negedge clk);
    if (xv3) vcnt++;
    model_chk("d3", q3, pos3, 3, ir3, xv3, xf3, xl3, bz3, x3, idx3);
    model_chk("d1", q1, pos1, 1, ir1, xv1, xf1, xl1, bz1, x1, {1'b0, idx1});
    @(posedge clk);
    model_upd(q3, pos3, 3);
    model_upd(q1, pos1, 1);
    #1;
  endtask

  initial begin
    tv[0] = '{1'b1, 1'b1, 1'b1, 24'h332211, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0};
    tv[1] = '{1'b0, 1'b0, 1'b1, 24'h332211, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0};
    tv[2] = '{1'b0, 1'b1, 1'b1, 24'h332211, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0};
    tv[3] = '{1'b0, 1'b0, 1'b1, 24'h332211, 1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 2'd0};
    tv[4] = '{1'b0, 1'b0, 1'b1, 24'h332211, 1'b1, 1'b1, 8'h22, 1'b0, 1'b0, 2'd1};
    tv[5] = '{1'b0, 1'b0, 1'b1, 24'h332211, 1'b1, 1'b1, 8'h33, 1'b0, 1'b1, 2'd2};
    tv[6] = '{1'b0, 1'b0, 1'b1, 24'h332211, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0};

    rst = 1'b1; in_valid = 1'b1; in_vec = 24'h332211; x_ready = 1'b1;
    @(posedge clk); #1;

    // Reset hold and single frame
    for (int i = 0; i < 7; i++) begin
      rst = tv[i].rst; in_valid = tv[i].iv; x_ready = tv[i].xr; in_vec = tv[i].vec;
      #1;
      chk($sformatf("tv%0d.in_ready", i), 32'(ir3),  32'(tv[i].e_ir));
      chk($sformatf("tv%0d.x_valid", i),  32'(xv3),  32'(tv[i].e_xv));
      chk($sformatf("tv%0d.busy", i),     32'(bz3),  32'(tv[i].e_xv));
      chk($sformatf("tv%0d.x", i),        32'(x3),   32'(tv[i].e_x));
      chk($sformatf("tv%0d.x_first", i),  32'(xf3),  32'(tv[i].e_f));
      chk($sformatf("tv%0d.x_last", i),   32'(xl3),  32'(tv[i].e_l));
      chk($sformatf("tv%0d.idx", i),      32'(idx3), 32'(tv[i].e_idx));
      tick();
    end

    // Back-to-back A, B, then C blocked until A retires
    vcnt = 0;
    in_valid = 1'b1; in_vec = 24'hA2A1A0; tick();
    in_vec = 24'hB2B1B0; tick();
    in_vec = 24'hC2C1C0; #1;
    chk("b2b.c_blocked", 32'(ir3), 32'(0));
    cw = 0;
    while (!ir3 && cw < 10) begin tick(); cw++; end
    chk("b2b.c_wait", 32'(cw), 32'(2));
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    chk("b2b.contig_valid", 32'(vcnt), 32'(9));

    // Backpressure at idx=1
    in_valid = 1'b1; in_vec = 24'hD2D1D0; tick();
    in_valid = 1'b0; tick();
    x_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("bp.idx", 32'(idx3), 32'(1));
      chk("bp.x", 32'(x3), 32'(8'hD1));
      chk("bp.flags", 32'({xv3, xf3, xl3}), 32'(3'b100));
      tick();
    end
    x_ready = 1'b1; tick();
    chk("bp.resume_idx", 32'(idx3), 32'(2));
    chk("bp.resume_x", 32'(x3), 32'(8'hD2));
    tick();

    // Load coinciding with retire in ONE, then reset mid-vector
    in_valid = 1'b1; in_vec = 24'hE2E1E0; tick();
    in_valid = 1'b0; tick(); tick();
    in_valid = 1'b1; in_vec = 24'hF2F1F0; #1;
    chk("sim.at_last", 32'(idx3), 32'(2));
    tick();
    in_valid = 1'b0; #1;
    chk("sim.next_first", 32'(xf3), 32'(1));
    chk("sim.next_x", 32'(x3), 32'(8'hF0));
    chk("sim.one_ready", 32'(ir3), 32'(1));
    tick();
    chk("rst.at_idx1", 32'(idx3), 32'(1));
    rst = 1'b1; tick();
    rst = 1'b0; #1;
    chk("rst.x_valid", 32'(xv3), 32'(0));
    chk("rst.busy", 32'(bz3), 32'(0));
    tick(); tick();

    // VEC_SIZE=1 full throughput
    x_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_vec = {16'h0, 8'(i * 17 + 5)};
      tick();
      chk("v1.x", 32'(x1), 32'(8'(i * 17 + 5)));
      chk("v1.flags", 32'({xv1, xf1, xl1}), 32'(3'b111));
    end
    in_valid = 1'b0;
    repeat (6) tick();

    // Randomized traffic against the frame model
    for (int i = 0; i < 800; i++) begin
      rst      = ($urandom_range(0, 59) == 0);
      in_valid = 1'($urandom_range(0, 1));
      x_ready  = ($urandom_range(0, 3) != 0);
      in_vec   = 24'($urandom);
      tick();
    end
    rst = 1'b0; in_valid = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
